// File: rtl/riscv_pkg.sv
// Shared fetch/decode definitions: default widths, bubble encoding, entry layout.
// No logic; latency n/a; backpressure n/a.
package riscv_pkg;

  localparam int DEFAULT_ADDRESS_BITS = 16;
  localparam int DEFAULT_DATA_WIDTH   = 32;

  // addi x0, x0, 0 -- inserted by decode when it needs a bubble
  localparam logic [DEFAULT_DATA_WIDTH-1:0] NOP_INSTRUCTION = 32'h00000013;

  typedef struct packed {
    logic [DEFAULT_ADDRESS_BITS-1:0] pc;
    logic [DEFAULT_DATA_WIDTH-1:0]   instruction;
  } fetch_entry_t;

endpackage

// File: rtl/queue_storage.sv
// Register array, one write port, one combinational read port, async clear.
// Write visible after the edge; read is zero-latency; no backpressure.
module queue_storage #(
  parameter int DEPTH    = 4,
  parameter int WIDTH    = 48,
  parameter int PTR_BITS = $clog2(DEPTH)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                wr_en,
  input  logic [PTR_BITS-1:0] wr_ptr,
  input  logic [WIDTH-1:0]    wr_dat,
  input  logic [PTR_BITS-1:0] rd_ptr,
  output logic [WIDTH-1:0]    rd_dat
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en) begin
      mem[wr_ptr] <= wr_dat;
    end
  end

  assign rd_dat = mem[rd_ptr];

endmodule

// File: rtl/fetch_decode_queue.sv
// Fetch-to-decode instruction queue with flush on redirect.
// Push on edge N is visible at decode after edge N; 1 entry/cycle sustained.
// fetch_ready drops when full (registered count only); flush empties the queue.
module fetch_decode_queue
  import riscv_pkg::*;
#(
  parameter int ADDRESS_BITS = DEFAULT_ADDRESS_BITS,
  parameter int DATA_WIDTH   = DEFAULT_DATA_WIDTH,
  parameter int DEPTH        = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       fetch_valid,
  input  logic [ADDRESS_BITS-1:0]    fetch_PC,
  input  logic [DATA_WIDTH-1:0]      fetch_instruction,
  output logic                       fetch_ready,
  output logic                       decode_valid,
  output logic [ADDRESS_BITS-1:0]    decode_PC,
  output logic [DATA_WIDTH-1:0]      decode_instruction,
  input  logic                       decode_ready,
  output logic [$clog2(DEPTH):0]     occupancy
);

  localparam int PTR_BITS = $clog2(DEPTH);
  localparam int CNT_BITS = PTR_BITS + 1;
  localparam int WIDTH    = ADDRESS_BITS + DATA_WIDTH;

  logic [PTR_BITS-1:0] head;
  logic [PTR_BITS-1:0] tail;
  logic [CNT_BITS-1:0] count;
  logic                push;
  logic                pop;
  logic [WIDTH-1:0]    rd_dat;

  assign fetch_ready  = (count != CNT_BITS'(DEPTH));
  assign decode_valid = (count != '0);
  assign push         = fetch_valid & fetch_ready;
  assign pop          = decode_valid & decode_ready;
  assign occupancy    = count;

  // Storage is not cleared on flush, so mask the head read with count.
  assign decode_PC          = decode_valid ? rd_dat[WIDTH-1:DATA_WIDTH] : '0;
  assign decode_instruction = decode_valid ? rd_dat[DATA_WIDTH-1:0]     : '0;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        tail <= tail + PTR_BITS'(1);
      end
      if (pop) begin
        head <= head + PTR_BITS'(1);
      end
      if (push && !pop) begin
        count <= count + CNT_BITS'(1);
      end else if (pop && !push) begin
        count <= count - CNT_BITS'(1);
      end
    end
  end

  queue_storage #(
    .DEPTH    (DEPTH),
    .WIDTH    (WIDTH),
    .PTR_BITS (PTR_BITS)
  ) u_storage (
    .clock  (clock),
    .reset  (reset),
    .wr_en  (push & ~flush),
    .wr_ptr (tail),
    .wr_dat ({fetch_PC, fetch_instruction}),
    .rd_ptr (head),
    .rd_dat (rd_dat)
  );

endmodule

// File: tb/tb_fetch_decode_queue.sv
// Scoreboard bench for fetch_decode_queue: inputs driven and outputs sampled on negedge.
module tb_fetch_decode_queue;

  logic        clock;
  logic        reset;
  logic        flush;
  logic        fetch_valid;
  logic [15:0] fetch_PC;
  logic [31:0] fetch_instruction;
  logic        fetch_ready;
  logic        decode_valid;
  logic [15:0] decode_PC;
  logic [31:0] decode_instruction;
  logic        decode_ready;
  logic [2:0]  occupancy;

  int n_cmp = 0;
  int n_bad = 0;

  logic [47:0] sb [$];

  fetch_decode_queue #(
    .ADDRESS_BITS (16),
    .DATA_WIDTH   (32),
    .DEPTH        (4)
  ) dut (
    .clock              (clock),
    .reset              (reset),
    .flush              (flush),
    .fetch_valid        (fetch_valid),
    .fetch_PC           (fetch_PC),
    .fetch_instruction  (fetch_instruction),
    .fetch_ready        (fetch_ready),
    .decode_valid       (decode_valid),
    .decode_PC          (decode_PC),
    .decode_instruction (decode_instruction),
    .decode_ready       (decode_ready),
    .occupancy          (occupancy)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] instr_of(input logic [15:0] pc);
    return {~pc, pc};
  endfunction

  // Called just after a negedge: drive, check against model, advance model, step one cycle.
  task automatic step(input logic v, input logic [15:0] pc, input logic dr,
                      input logic fl, output logic accepted);
    logic model_ready;
    fetch_valid       = v;
    fetch_PC          = pc;
    fetch_instruction = instr_of(pc);
    decode_ready      = dr;
    flush             = fl;
    #1;
    model_ready = (sb.size() != 4);
    chk("occupancy", 48'(occupancy), 48'(sb.size()));
    chk("fetch_ready", 48'(fetch_ready), 48'(model_ready));
    chk("decode_valid", 48'(decode_valid), 48'(sb.size() != 0));
    if (sb.size() != 0) begin
      chk("decode_head", {decode_PC, decode_instruction}, sb[0]);
    end else begin
      chk("decode_zero", {decode_PC, decode_instruction}, 48'h0);
    end
    accepted = 1'b0;
    if (fl) begin
      sb.delete();
    end else begin
      if (dr && sb.size() != 0) void'(sb.pop_front());
      if (v && model_ready) begin
        sb.push_back({pc, instr_of(pc)});
        accepted = 1'b1;
      end
    end
    @(posedge clock);
    @(negedge clock);
  endtask

  initial begin
    logic        acc;
    logic [15:0] pc_next;

    // Test 1: reset held with fetch_valid high
    reset = 1'b0;
    flush = 1'b0;
    fetch_valid = 1'b1;
    fetch_PC = 16'h0abc;
    fetch_instruction = 32'hdeadbeef;
    decode_ready = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst_occupancy", 48'(occupancy), 48'h0);
    chk("rst_decode_valid", 48'(decode_valid), 48'h0);
    chk("rst_decode_PC", 48'(decode_PC), 48'h0);
    chk("rst_fetch_ready", 48'(fetch_ready), 48'h1);
    reset = 1'b1;

    // Test 2: fill, then a refused 5th push
    for (int i = 0; i < 4; i++) step(1'b1, 16'(i * 4), 1'b0, 1'b0, acc);
    chk("full_fetch_ready", 48'(fetch_ready), 48'h0);
    chk("full_head", 48'(decode_PC), 48'h0000);
    step(1'b1, 16'h0010, 1'b0, 1'b0, acc);
    chk("fifth_refused", 48'(acc), 48'h0);

    // Test 3: drain while fetch keeps re-presenting 0010/0014
    pc_next = 16'h0010;
    for (int i = 0; i < 20 && pc_next != 16'h0018; i++) begin
      step(1'b1, pc_next, 1'b1, 1'b0, acc);
      if (acc) pc_next = pc_next + 16'h4;
    end
    chk("wrap_pushed_all", 48'(pc_next), 48'h0018);
    for (int i = 0; i < 10 && sb.size() != 0; i++) step(1'b0, 16'h0, 1'b1, 1'b0, acc);
    chk("drained", 48'(occupancy), 48'h0);

    // Test 4: push+pop at occupancy 2
    step(1'b1, 16'h0100, 1'b0, 1'b0, acc);
    step(1'b1, 16'h0104, 1'b0, 1'b0, acc);
    for (int i = 0; i < 6; i++) step(1'b1, 16'(16'h0108 + i * 4), 1'b1, 1'b0, acc);
    chk("steady_occupancy", 48'(occupancy), 48'h2);
    chk("steady_head", 48'(decode_PC), 48'h0118);

    // Test 5: flush at occupancy 3 drops the concurrent push
    step(1'b1, 16'h0200, 1'b0, 1'b0, acc);
    step(1'b1, 16'h1111, 1'b0, 1'b1, acc);
    chk("flush_occupancy", 48'(occupancy), 48'h0);
    chk("flush_valid", 48'(decode_valid), 48'h0);
    step(1'b1, 16'h1111, 1'b0, 1'b0, acc);
    chk("redirect_PC", 48'(decode_PC), 48'h1111);
    step(1'b0, 16'h0, 1'b1, 1'b0, acc);

    // Test 6: async reset between edges at occupancy 2
    step(1'b1, 16'h0300, 1'b0, 1'b0, acc);
    step(1'b1, 16'h0304, 1'b0, 1'b0, acc);
    fetch_valid = 1'b0;
    chk("pre_rst_occupancy", 48'(occupancy), 48'h2);
    #2 reset = 1'b0;
    #1;
    chk("async_occupancy", 48'(occupancy), 48'h0);
    chk("async_valid", 48'(decode_valid), 48'h0);
    chk("async_PC", 48'(decode_PC), 48'h0);
    chk("async_instr", 48'(decode_instruction), 48'h0);
    chk("async_fetch_ready", 48'(fetch_ready), 48'h1);
    sb.delete();
    @(negedge clock);
    reset = 1'b1;
    step(1'b1, 16'h0020, 1'b0, 1'b0, acc);
    chk("post_rst_PC", 48'(decode_PC), 48'h0020);
    step(1'b0, 16'h0, 1'b1, 1'b0, acc);
    step(1'b0, 16'h0, 1'b0, 1'b0, acc);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fetch_decode_queue.md
Name: fetch_decode_queue

Overview:
Buffers fetched instructions between the fetch stage and decode. Each entry holds a PC with its instruction word. Entries are handed to decode under a valid/ready handshake. When the queue fills, it back-pressures fetch so the PC holds. A control-flow redirect (next_PC_select) flushes every entry in flight.

Parameters:
ADDRESS_BITS, 16, width of PC fields; must match the fetch stage.
DATA_WIDTH, 32, instruction word width.
DEPTH, 4, number of entries; power of two, minimum 2.

Ports:
clock  input  1  single clock; all state updates on its rising edge.
reset  input  1  asynchronous, active-low reset (0 = reset asserted); assertion takes effect immediately, deassertion is sampled on clock.
flush  input  1  redirect; driven by next_PC_select from branch/jump resolution.
fetch_valid  input  1  fetch side presents an entry this cycle.
fetch_PC  input  ADDRESS_BITS  PC of the presented instruction.
fetch_instruction  input  DATA_WIDTH  instruction word read at fetch_PC.
fetch_ready  output  1  queue accepts an entry this cycle; also used as the fetch PC-advance enable.
decode_valid  output  1  head entry is valid.
decode_PC  output  ADDRESS_BITS  PC of the head entry.
decode_instruction  output  DATA_WIDTH  instruction of the head entry.
decode_ready  input  1  decode consumes the head entry this cycle.
occupancy  output  clog2(DEPTH)+1  number of valid entries.

Behaviour:
- State:
  - DEPTH-entry storage array.
  - head and tail pointers, each clog2(DEPTH) bits, wrapping modulo DEPTH.
  - count register, clog2(DEPTH)+1 bits.
- push = fetch_valid & fetch_ready. pop = decode_valid & decode_ready.
- fetch_ready = (count != DEPTH). It depends only on registered count, never on decode_ready. A full queue therefore refuses a push even when a pop happens in the same cycle.
- decode_valid = (count != 0).
- decode_PC and decode_instruction read the head entry combinationally. When count == 0 they drive all zeros, not stale data.
- Latency: an entry pushed on edge N appears at the decode outputs after edge N. Minimum fetch-to-decode latency is 1 cycle. Throughput is 1 entry/cycle in steady state.
- Per edge, in priority order:
  - flush = 1: head = tail = 0 and count = 0. Any push or pop in that cycle is discarded. Storage contents need not be cleared because outputs are masked by count.
  - otherwise push only: write at tail, tail+1, count+1.
  - otherwise pop only: head+1, count-1.
  - otherwise push and pop together: write at tail, tail+1, head+1, count unchanged. This is legal at any count from 1 to DEPTH-1.
  - otherwise no change.
- Boundaries:
  - Pop when empty cannot occur, because decode_valid = 0.
  - Push when full cannot occur, because fetch_ready = 0.
  - Pointer wrap from DEPTH-1 to 0 is seamless.
  - A flush arriving in the same cycle as a push of the redirect target is dropped. The fetch stage re-presents the target on the following cycle.
- Reset (reset = 0, any time, including mid-transfer):
  - Immediately: head = tail = count = 0 and all storage = 0.
  - Outputs: decode_valid = 0, decode_PC = 0, decode_instruction = 0, occupancy = 0, fetch_ready = 1.
  - Inputs are ignored while reset = 0.
- Error-free by construction: there is no overflow or underflow flag.

Decomposition:
- Shared package riscv_pkg:
  - ADDRESS_BITS and DATA_WIDTH defaults.
  - NOP_INSTRUCTION constant 32'h00000013, reserved for the decode-side bubble insertion.
  - Typedef fetch_entry_t = {PC, instruction}.
- One natural sub-module, queue_storage:
  - DEPTH x (ADDRESS_BITS+DATA_WIDTH) register array.
  - Async active-low clear, single write port, single combinational read port.
  - The pointer/count controller stays in fetch_decode_queue.

Test Plan:
1. Reset: hold reset = 0 for 2 cycles with fetch_valid = 1 -> occupancy = 0, decode_valid = 0, decode_PC = 0000, fetch_ready = 1.
2. Fill: push PCs 0000, 0004, 0008, 000C with decode_ready = 0 -> occupancy 1..4; after the 4th edge fetch_ready = 0; decode_PC = 0000; a 5th push of 0010 is ignored.
3. Drain and wrap: after test 2, set decode_ready = 1 and resume pushing 0010, 0014 -> PCs emerge in order 0000, 0004, 0008, 000C, 0010, 0014 with no gaps or duplicates; head/tail wrap past index 3.
4. Simultaneous push and pop at occupancy 2 for 6 cycles -> occupancy stays 2; decode sees consecutive PCs at one per cycle.
5. Flush: at occupancy 3, assert flush together with a push of 1111 -> next cycle occupancy = 0, decode_valid = 0; a push of 1111 on the following cycle appears as decode_PC = 1111 one edge later.
6. Mid-operation reset: at occupancy 2, pulse reset = 0 between clock edges -> outputs clear immediately without waiting for an edge; after release, the first push of 0020 yields decode_PC = 0020.
